// File: rtl/mdc_pkg.sv
// Shared types and defaults for the subtractive GCD (MDC) engine.
package mdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdc_state_e;

    localparam int MDC_WIDTH_DEF = 8;

endpackage

// File: rtl/mdc_step.sv
// One compare/subtract step of the subtractive GCD, purely combinational.
module mdc_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] next_x,
    output logic [WIDTH-1:0] next_y,
    output logic             terminal,
    output logic [WIDTH-1:0] result,
    output logic             is_zero,
    output logic             sub
);

    // The smaller operand is always the subtrahend, so no underflow is possible.
    always_comb begin
        next_x   = x;
        next_y   = y;
        terminal = 1'b0;
        result   = x;
        is_zero  = 1'b0;
        sub      = 1'b0;
        if ((x == '0) || (y == '0)) begin
            terminal = 1'b1;
            result   = (x > y) ? x : y;
            is_zero  = (x == '0) && (y == '0);
        end else if (x > y) begin
            next_x = x - y;
            sub    = 1'b1;
        end else if (y > x) begin
            next_y = y - x;
            sub    = 1'b1;
        end else begin
            terminal = 1'b1;
            result   = x;
        end
    end

endmodule

// File: rtl/mdc_engine.sv
// WIDTH-bit subtractive GCD engine with valid/ready handshakes and abort.
// Define MDC_ITER_CNT_EN to add the iter_o subtraction counter.
module mdc_engine
    import mdc_pkg::*;
#(
    parameter int WIDTH = MDC_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dtx_i,
    input  logic [WIDTH-1:0] dty_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] dt_o,
    output logic             zero_o,
    output logic             operation_o
`ifdef MDC_ITER_CNT_EN
    ,
    output logic [WIDTH-1:0] iter_o
`endif
);

    mdc_state_e       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, dt_q, dt_d;
    logic             zero_q, zero_d, out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic [WIDTH-1:0] step_next_x, step_next_y, step_result;
    logic             step_terminal, step_is_zero, step_sub;
    logic             load_s;

    mdc_step #(.WIDTH(WIDTH)) u_step (
        .x        (x_q),
        .y        (y_q),
        .next_x   (step_next_x),
        .next_y   (step_next_y),
        .terminal (step_terminal),
        .result   (step_result),
        .is_zero  (step_is_zero),
        .sub      (step_sub)
    );

    assign load_s      = ~clr_i && (state_q == IDLE) && in_valid_i;
    assign operation_o = (state_q == CALC) && step_sub;

    // Next-state and datapath; abort wins over every handshake.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dt_d    = dt_q;
        zero_d  = zero_q;
        if (clr_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_s) begin
                        x_d     = dtx_i;
                        y_d     = dty_i;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    if (step_terminal) begin
                        dt_d    = step_result;
                        zero_d  = step_is_zero;
                        state_d = DONE;
                    end else begin
                        x_d = step_next_x;
                        y_d = step_next_y;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // FSM and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            dt_q        <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dt_q        <= dt_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign dt_o        = dt_q;
    assign zero_o      = zero_q;
    assign out_valid_o = out_valid_q;
    assign in_ready_o  = in_ready_q;

`ifdef MDC_ITER_CNT_EN
    logic [WIDTH-1:0] iter_q, iter_d;

    // Counter cannot overflow: at most 2^WIDTH-2 subtractions per operation.
    always_comb begin
        if (load_s) begin
            iter_d = '0;
        end else if (operation_o) begin
            iter_d = iter_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            iter_d = iter_q;
        end
    end

    // Subtraction counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iter_q <= '0;
        end else begin
            iter_q <= iter_d;
        end
    end

    assign iter_o = iter_q;
`endif

endmodule

// File: tb/tb_mdc_engine.sv
// Self-checking bench for mdc_engine (WIDTH=8 and WIDTH=16 instances).
module tb_mdc_engine;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, w_in_valid, out_ready;
    logic [15:0] dx, dy;
    logic        in_ready, out_valid, zero, op;
    logic [7:0]  dt;
    logic        w_in_ready, w_out_valid, w_zero, w_op;
    logic [15:0] w_dt;
    logic        sel_wide;
    logic        s_in_ready, s_out_valid, s_zero, s_op;
    logic [15:0] s_dt;
    int          total = 0;
    int          bad = 0;
    int unsigned last_g = 0;
`ifdef MDC_ITER_CNT_EN
    logic [7:0]  iter;
    logic [15:0] w_iter, s_iter;
`endif

    always #5 clk = ~clk;

    mdc_engine #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .dtx_i(dx[7:0]), .dty_i(dy[7:0]), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .dt_o(dt), .zero_o(zero), .operation_o(op)
`ifdef MDC_ITER_CNT_EN
        , .iter_o(iter)
`endif
    );

    mdc_engine #(.WIDTH(16)) dut_w (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
        .dtx_i(dx), .dty_i(dy), .out_valid_o(w_out_valid), .out_ready_i(out_ready),
        .dt_o(w_dt), .zero_o(w_zero), .operation_o(w_op)
`ifdef MDC_ITER_CNT_EN
        , .iter_o(w_iter)
`endif
    );

    assign s_in_ready  = sel_wide ? w_in_ready  : in_ready;
    assign s_out_valid = sel_wide ? w_out_valid : out_valid;
    assign s_zero      = sel_wide ? w_zero      : zero;
    assign s_op        = sel_wide ? w_op        : op;
    assign s_dt        = sel_wide ? w_dt        : {8'h00, dt};
`ifdef MDC_ITER_CNT_EN
    assign s_iter      = sel_wide ? w_iter      : {8'h00, iter};
`endif

    // Reference: Euclid by division; the subtractive step count is the sum of
    // quotients, minus one on the exact division that ends at x==y.
    function automatic void model(input int unsigned a0, input int unsigned b0,
                                  output int unsigned g, output int unsigned k);
        int unsigned a, b, t, q, r;
        a = a0; b = b0; k = 0;
        while (a != 0 && b != 0 && a != b) begin
            if (a < b) begin t = a; a = b; b = t; end
            q = a / b; r = a % b;
            if (r == 0) begin k += q - 1; a = b; end
            else begin k += q; a = r; end
        end
        g = (a == 0) ? b : a;
    endfunction

    task automatic run_op(input bit wide, input int unsigned xa, input int unsigned ya);
        int unsigned g, k;
        int lat, ops;
        bit got, ez;
        model(xa, ya, g, k);
        ez = (xa == 0) && (ya == 0);
        sel_wide = wide;
        @(posedge clk); #1;
        total++;
        if (s_in_ready !== 1'b1) begin bad++; $display("FAIL ready_before x=%0d y=%0d got=%b exp=1", xa, ya, s_in_ready); end
        dx = xa[15:0]; dy = ya[15:0]; out_ready = 1'b1;
        if (wide) w_in_valid = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; w_in_valid = 1'b0;
        lat = 0; ops = 0; got = 1'b0;
        for (int n = 1; n <= 70000 && !got; n++) begin
            if (s_op === 1'b1) ops++;
            @(posedge clk); #1;
            lat = n;
            if (s_out_valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL timeout x=%0d y=%0d waited=%0d", xa, ya, lat); return; end
        total++;
        if (lat != int'(k) + 1) begin bad++; $display("FAIL latency x=%0d y=%0d got=%0d exp=%0d", xa, ya, lat, k + 1); end
        total++;
        if (ops != int'(k)) begin bad++; $display("FAIL op_cycles x=%0d y=%0d got=%0d exp=%0d", xa, ya, ops, k); end
        total++;
        if (s_dt !== g[15:0]) begin bad++; $display("FAIL dt x=%0d y=%0d got=%0d exp=%0d", xa, ya, s_dt, g); end
        total++;
        if (s_zero !== ez) begin bad++; $display("FAIL zero x=%0d y=%0d got=%b exp=%b", xa, ya, s_zero, ez); end
`ifdef MDC_ITER_CNT_EN
        total++;
        if (s_iter !== k[15:0]) begin bad++; $display("FAIL iter x=%0d y=%0d got=%0d exp=%0d", xa, ya, s_iter, k); end
`endif
        @(posedge clk); #1;
        total++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            bad++; $display("FAIL back_idle x=%0d y=%0d ready=%b valid=%b exp 1/0", xa, ya, s_in_ready, s_out_valid);
        end
        if (!wide) last_g = g;
        sel_wide = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; w_in_valid = 1'b0; out_ready = 1'b0;
        dx = 16'h0; dy = 16'h0; sel_wide = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({in_ready, out_valid, dt, zero, op} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_state rdy=%b vld=%b dt=%0d zero=%b op=%b exp 1/0/0/0/0", in_ready, out_valid, dt, zero, op);
        end
    endtask

    task automatic test_directed();
        run_op(1'b0, 12, 8);
        run_op(1'b0, 0, 9);
        run_op(1'b0, 0, 0);
        run_op(1'b0, 7, 7);
        run_op(1'b0, 255, 1);
        run_op(1'b0, 1, 255);
        run_op(1'b0, 9, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) run_op(1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic test_wide();
        run_op(1'b1, 65535, 65535);
        run_op(1'b1, 1000, 600);
        run_op(1'b1, $urandom_range(1, 400), $urandom_range(1, 400));
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        dx = 16'd60; dy = 16'd48; in_valid = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout waited=%0d", n); end
        dx = 16'd5; dy = 16'd10;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, dt} !== {1'b1, 1'b0, 8'd12}) begin
                bad++; $display("FAIL bp_hold cyc=%0d vld=%b rdy=%b dt=%0d exp 1/0/12", c, out_valid, in_ready, dt);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready, dt} !== {1'b0, 1'b1, 8'd12}) begin
            bad++; $display("FAIL bp_release vld=%b rdy=%b dt=%0d exp 0/1/12", out_valid, in_ready, dt);
        end
        last_g = 12;
    endtask

    task automatic test_abort();
        bit rose;
        dx = 16'd200; dy = 16'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        clr = 1'b1; in_valid = 1'b1; dx = 16'd5; dy = 16'd5;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        total++;
        if ({in_ready, out_valid, dt} !== {1'b1, 1'b0, last_g[7:0]}) begin
            bad++; $display("FAIL abort rdy=%b vld=%b dt=%0d exp 1/0/%0d", in_ready, out_valid, dt, last_g);
        end
        rose = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || in_ready !== 1'b1) rose = 1'b1;
        end
        total++;
        if (rose) begin bad++; $display("FAIL abort_quiet got=busy exp=idle"); end
    endtask

    task automatic test_reset_midcalc();
        dx = 16'd255; dy = 16'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, dt, zero, op} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL async_reset rdy=%b vld=%b dt=%0d zero=%b op=%b exp 1/0/0/0/0", in_ready, out_valid, dt, zero, op);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset vld=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_wide();
        test_backpressure();
        test_abort();
        test_reset_midcalc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
